// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen: prescaled rotate / ping-pong walking pattern generator for a GPIO bank
module gpio_pattern_gen #(
  parameter int WIDTH = 32,
  parameter int DIV_W = 24,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b1}}, 1'b0}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] pattern,
  output logic             tick,
  output logic             dir
);
  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
  logic [DIV_W-1:0] cnt;
  logic [PW-1:0]    pos, pos_inc, pos_dec, pos_n;
  logic [WIDTH-1:0] pattern_n;
  logic             go_left, go_right, dir_n, wrap;
  always_comb begin
    pos_inc   = (pos == POS_MAX) ? '0 : pos + 1'b1;
    pos_dec   = (pos == '0) ? POS_MAX : pos - 1'b1;
    go_left   = (mode == 2'b00) || (mode == 2'b10 && !dir);
    go_right  = (mode == 2'b01) || (mode == 2'b10 && dir);
    pattern_n = go_left  ? {pattern[WIDTH-2:0], pattern[WIDTH-1]} :
                go_right ? {pattern[0], pattern[WIDTH-1:1]} : pattern;
    pos_n     = go_left ? pos_inc : go_right ? pos_dec : pos;
    // ping-pong turns around in the same step that lands on an end position
    wrap      = dir ? (pos_n == '0) : (pos_n == POS_MAX);
    dir_n     = (mode == 2'b10 && wrap) ? ~dir : dir;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      tick    <= 1'b0;
      pattern <= RESET_PATTERN;
      pos     <= '0;
      dir     <= 1'b0;
    end else begin
      cnt  <= (!en || cnt == div) ? '0 : cnt + 1'b1;
      tick <= en && (cnt == div);
      if (load) begin
        pattern <= load_data;
        pos     <= '0;
        dir     <= 1'b0;
      end else if (tick) begin
        pattern <= pattern_n;
        pos     <= pos_n;
        dir     <= dir_n;
      end
    end
  end
endmodule

// File: tb/tb_gpio_pattern_gen.sv
// tb_gpio_pattern_gen: directed self-checking bench for gpio_pattern_gen (WIDTH=8, DIV_W=8)
module tb_gpio_pattern_gen;
  logic       clk = 1'b0, rstn = 1'b1, en = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] div = 8'd3, load_data = 8'h00;
  logic [7:0] pattern;
  logic       tick, dir;
  int         passed = 0, total = 0, n;
  always #5 clk = ~clk;
  gpio_pattern_gen #(.WIDTH(8), .DIV_W(8)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .div(div), .load(load),
    .load_data(load_data), .pattern(pattern), .tick(tick), .dir(dir)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  initial begin
    en = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("rst_pattern", pattern, 8'hFE);
    chk("rst_tick", tick, 1'b0);
    chk("rst_dir", dir, 1'b0);
    chk("rst_pos", dut.pos, 3'd0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(3);
    chk("no_early_tick", tick, 1'b0);
    cyc(1);
    chk("first_tick", tick, 1'b1);
    chk("pat_before_step", pattern, 8'hFE);
    cyc(1);
    chk("rol_step1", pattern, 8'hFD);
    chk("tick_one_cycle", tick, 1'b0);
    cyc(3);
    chk("second_tick", tick, 1'b1);
    cyc(1);
    chk("rol_step2", pattern, 8'hFB);
    cyc(24);
    chk("rol_step8", pattern, 8'hFE);
    mode = 2'b11;
    cyc(11);
    chk("hold_third_tick", tick, 1'b1);
    chk("hold_pat_mid", pattern, 8'hFE);
    cyc(1);
    chk("hold_pat_end", pattern, 8'hFE);
    mode = 2'b01;
    cyc(4);
    chk("ror_after_hold", pattern, 8'h7F);
    chk("ror_dir", dir, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("en0_tick", tick, 1'b0);
      chk("en0_pat", pattern, 8'h7F);
    end
    en = 1'b1;
    cyc(3);
    chk("reen_no_tick", tick, 1'b0);
    cyc(1);
    chk("reen_tick", tick, 1'b1);
    cyc(1);
    chk("reen_step", pattern, 8'hBF);
    div = 8'd0;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!tick && n < 300);
    chk("div_lowered_wrap", n, 256);
    chk("wrap_pat_frozen", pattern, 8'hBF);
    cyc(1);
    chk("wrap_step", pattern, 8'hDF);
    mode = 2'b10;
    load = 1'b1;
    load_data = 8'h01;
    cyc(1);
    load = 1'b0;
    chk("pp_load", pattern, 8'h01);
    for (int i = 1; i <= 14; i++) begin
      logic [7:0] e;
      e = (i <= 7) ? 8'(1 << i) : 8'(1 << (14 - i));
      cyc(1);
      chk($sformatf("pp_pat_%0d", i), pattern, e);
      chk($sformatf("pp_dir_%0d", i), dir, (i >= 7 && i < 14));
    end
    cyc(7);
    chk("pp_pat_21", pattern, 8'h80);
    chk("pp_dir_21", dir, 1'b1);
    load = 1'b1;
    load_data = 8'hA5;
    chk("load_with_tick", tick, 1'b1);
    cyc(1);
    load = 1'b0;
    chk("load_pat", pattern, 8'hA5);
    chk("load_dir", dir, 1'b0);
    chk("load_pos", dut.pos, 3'd0);
    cyc(1);
    chk("after_load_step", pattern, 8'h4B);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_pat", pattern, 8'hFE);
    chk("async_rst_tick", tick, 1'b0);
    chk("async_rst_dir", dir, 1'b0);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("release_no_step", pattern, 8'hFE);
    chk("release_tick", tick, 1'b1);
    cyc(1);
    chk("post_release_step", pattern, 8'hFD);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
